m_op_seq: RTL and testbench
===========================

M_OP_SEQ -- requirements
Module: m_op_seq

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue depth in entries, power of two, at least 2.
REQ-002 Parameter IDLE_OP, default 3'b011: opcode driven when no instruction is issued; OR with data 0 leaves the downstream ALU's acc and shift unchanged.
REQ-003 Parameter DIV_OP, default 3'b101: opcode checked for divide-by-zero.
REQ-004 Port clk, input, 1 bit: the block's single clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port clear, input, 1 bit: synchronous flush.
REQ-007 Port in_instr, input, 13 bits: [12:11] repeat count rep, [10:8] opcode, [7:0] operand.
REQ-008 Port in_valid, input, 1 bit: in_instr is valid.
REQ-009 Port in_ready, output, 1 bit: the queue can accept an instruction.
REQ-010 Port stall, input, 1 bit: hold issue.
REQ-011 Port operation, output, 3 bits, registered: opcode to the ALU.
REQ-012 Port data, output, 8 bits, registered: operand to the ALU.
REQ-013 Port issue_valid, output, 1 bit, registered: operation/data carry a real instruction this cycle.
REQ-014 Port busy, output, 1 bit: queue non-empty or repeats outstanding.
REQ-015 Port div0_err, output, 1 bit, registered, sticky: a DIV with operand 0 was dropped.
REQ-016 Port level, output, $clog2(DEPTH)+1 bits: current queue occupancy.

Function
REQ-017 The queue SHALL be a circular FIFO with wrapping read and write pointers and an occupancy counter 0..DEPTH.
REQ-018 in_ready SHALL equal (level != DEPTH), combinational from level only; a push into a full queue is not allowed even when a pop occurs in the same cycle.
REQ-019 A push SHALL occur on an edge where in_valid && in_ready && !clear.
REQ-020 Each rising edge SHALL apply the first matching rule below (REQ-021 to REQ-025).
REQ-021 clear=1: empty the queue, set rem=0, operation=IDLE_OP, data=0, issue_valid=0, div0_err=0, and ignore any push.
REQ-022 stall=1: operation=IDLE_OP, data=0, issue_valid=0; rem and the queue SHALL NOT be popped, though pushes still occur.
REQ-023 rem>0: reissue the held opcode and operand, issue_valid=1, rem decrements by 1.
REQ-024 Queue non-empty: pop the head; if head is DIV_OP with operand 0, drive idle outputs, issue_valid=0, div0_err=1, rem=0 (instruction dropped); otherwise drive head opcode and operand, issue_valid=1, rem=head.rep.
REQ-025 Otherwise: operation=IDLE_OP, data=0, issue_valid=0.
REQ-026 Each instruction SHALL therefore issue rep+1 consecutive non-stalled cycles (1 to 4).
REQ-027 Latency: an instruction pushed into an empty, idle, unstalled block at edge N SHALL appear on operation/data with issue_valid=1 after edge N+1.
REQ-028 Simultaneous push and pop SHALL leave level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-029 busy SHALL equal (level != 0) || (rem != 0).
REQ-030 Pops SHALL only occur while rem==0, so back-to-back instructions SHALL issue with no idle gap.

Reset
REQ-031 While reset=1, asynchronously: level=0, pointers=0, rem=0, operation=IDLE_OP, data=0, issue_valid=0, div0_err=0.
REQ-032 Reset asserted mid-repeat or with a non-empty queue SHALL discard all pending instructions; no issue SHALL occur on the first edge after release unless a push happened earlier.
REQ-033 Queue storage contents need not be reset.

Verification
REQ-034 Push {rep=0, op=000, data=0x05} at edge 1 -> after edge 2: operation=000, data=0x05, issue_valid=1; after edge 3: operation=011, data=0x00, issue_valid=0.
REQ-035 Push {rep=3, op=000, data=0x01}, then {rep=0, op=001, data=0x02} -> four ADD 0x01 cycles, then SUB 0x02 with no gap; busy deasserts the cycle after the SUB issues.
REQ-036 Push 5 instructions back-to-back while stall=1 -> in_ready=0 when level=4, fifth is held off; release stall -> all four issue in order, then the fifth.
REQ-037 Push {op=101, data=0x00}, then {op=101, data=0x02} -> first is dropped with issue_valid=0 and div0_err=1; DIV 0x02 issues next; div0_err stays 1 until clear.
REQ-038 Assert stall mid-repeat (rep=2, after the first issue) for 2 cycles -> idle outputs for 2 cycles, then the remaining 2 issues.
REQ-039 Assert reset mid-repeat with level=3 -> outputs idle and level=0 immediately; after release, no issue until a new push.
REQ-040 clear asserted together with in_valid=1 -> queue empty, push ignored, div0_err=0.

Source files
------------

// File: rtl/m_op_seq.sv
// Purpose: queues ALU instructions and issues each one (rep+1) times to the ALU, dropping DIV by zero.
// Latency: an instruction pushed into an empty, idle block appears on the outputs one edge after its push edge.
// Backpressure: in_ready drops when the queue is full; stall holds issue while pushes continue.
module m_op_seq #(
  parameter int         DEPTH   = 4,
  parameter logic [2:0] IDLE_OP = 3'b011,
  parameter logic [2:0] DIV_OP  = 3'b101
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [12:0]             in_instr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    stall,
  output logic [2:0]              operation,
  output logic [7:0]              data,
  output logic                    issue_valid,
  output logic                    busy,
  output logic                    div0_err,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Instruction storage; contents are don't-care until written, so no reset.
  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Remaining reissues of the instruction currently held, plus its opcode/operand.
  // Kept apart from operation/data because a stall idles the outputs mid-repeat.
  logic [1:0]    rem;
  logic [2:0]    hold_op;
  logic [7:0]    hold_dat;

  logic [12:0]   head;
  logic [1:0]    head_rep;
  logic [2:0]    head_op;
  logic [7:0]    head_dat;
  logic          push;
  logic          pop;
  logic          head_div0;

  assign head      = mem[rptr];
  assign head_rep  = head[12:11];
  assign head_op   = head[10:8];
  assign head_dat  = head[7:0];
  assign head_div0 = (head_op == DIV_OP) && (head_dat == 8'h00);

  // Full check looks at level only: a same-cycle pop never frees a slot for a push.
  assign in_ready = (level != FULL);
  assign push     = in_valid && in_ready && !clear;
  // The head is only taken once the current instruction has finished repeating.
  assign pop      = !clear && !stall && (rem == 2'd0) && (level != '0);
  assign busy     = (level != '0) || (rem != 2'd0);

  // Queue write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_instr;
    end
  end

  // Queue pointers, occupancy and the issue sequencer with registered ALU outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      rem         <= 2'd0;
      hold_op     <= IDLE_OP;
      hold_dat    <= 8'h00;
      operation   <= IDLE_OP;
      data        <= 8'h00;
      issue_valid <= 1'b0;
      div0_err    <= 1'b0;
    end else if (clear) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      rem         <= 2'd0;
      operation   <= IDLE_OP;
      data        <= 8'h00;
      issue_valid <= 1'b0;
      div0_err    <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      level <= level + LW'(push) - LW'(pop);

      if (stall) begin
        operation   <= IDLE_OP;
        data        <= 8'h00;
        issue_valid <= 1'b0;
      end else if (rem != 2'd0) begin
        operation   <= hold_op;
        data        <= hold_dat;
        issue_valid <= 1'b1;
        rem         <= rem - 2'd1;
      end else if (level != '0) begin
        if (head_div0) begin
          // Divide by zero: drop the instruction and flag it until the next clear.
          operation   <= IDLE_OP;
          data        <= 8'h00;
          issue_valid <= 1'b0;
          div0_err    <= 1'b1;
          rem         <= 2'd0;
        end else begin
          operation   <= head_op;
          data        <= head_dat;
          issue_valid <= 1'b1;
          hold_op     <= head_op;
          hold_dat    <= head_dat;
          rem         <= head_rep;
        end
      end else begin
        operation   <= IDLE_OP;
        data        <= 8'h00;
        issue_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m_op_seq.sv
// Purpose: directed self-checking bench for the instruction sequencer.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: exercises full-queue hold-off, stall, clear and reset.
module tb_m_op_seq;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [12:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic [2:0]  operation;
  logic [7:0]  data;
  logic        issue_valid;
  logic        busy;
  logic        div0_err;
  logic [2:0]  level;

  int checks;
  int errors;

  localparam logic [2:0] IDLE = 3'b011;

  m_op_seq #(.DEPTH(4), .IDLE_OP(3'b011), .DIV_OP(3'b101)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_instr    (in_instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .stall       (stall),
    .operation   (operation),
    .data        (data),
    .issue_valid (issue_valid),
    .busy        (busy),
    .div0_err    (div0_err),
    .level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] mk(input logic [1:0] rep, input logic [2:0] op, input logic [7:0] d);
    return {rep, op, d};
  endfunction

  task automatic chk_out(input string tag, input logic [2:0] op, input logic [7:0] d, input logic iv);
    chk({tag, ".op"}, 16'(operation), 16'(op));
    chk({tag, ".data"}, 16'(data), 16'(d));
    chk({tag, ".iv"}, 16'(issue_valid), 16'(iv));
  endtask

  task automatic push_one(input logic [12:0] ins);
    in_instr = ins;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    clear    = 1'b0;
    in_instr = '0;
    in_valid = 1'b0;
    stall    = 1'b0;
    #12;
    // Reset state
    chk_out("rst", IDLE, 8'h00, 1'b0);
    chk("rst.level", 16'(level), 16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.div0", 16'(div0_err), 16'd0);
    chk("rst.rdy", 16'(in_ready), 16'd1);
    tick();
    reset = 1'b0;
    tick();

    // Single issue, latency and return to idle
    push_one(mk(2'd0, 3'b000, 8'h05));
    chk("s1.level", 16'(level), 16'd1);
    chk("s1.iv0", 16'(issue_valid), 16'd0);
    tick();
    chk_out("s1.e2", 3'b000, 8'h05, 1'b1);
    tick();
    chk_out("s1.e3", IDLE, 8'h00, 1'b0);
    chk("s1.busy", 16'(busy), 16'd0);

    // Repeat then back-to-back with no gap
    in_instr = mk(2'd3, 3'b000, 8'h01);
    in_valid = 1'b1;
    tick();
    in_instr = mk(2'd0, 3'b001, 8'h02);
    tick();
    in_valid = 1'b0;
    chk_out("s2.add0", 3'b000, 8'h01, 1'b1);
    chk("s2.level", 16'(level), 16'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_out($sformatf("s2.add%0d", i), 3'b000, 8'h01, 1'b1);
    end
    chk("s2.busy1", 16'(busy), 16'd1);
    tick();
    chk_out("s2.sub", 3'b001, 8'h02, 1'b1);
    chk("s2.busy0", 16'(busy), 16'd0);
    tick();
    chk_out("s2.idle", IDLE, 8'h00, 1'b0);

    // Fill while stalled, fifth held off, then drain in order
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = mk(2'd0, 3'(i), 8'(8'h10 + i));
      in_valid = 1'b1;
      tick();
      chk($sformatf("s3.lvl%0d", i), 16'(level), 16'(i + 1));
      chk_out($sformatf("s3.stall%0d", i), IDLE, 8'h00, 1'b0);
    end
    in_instr = mk(2'd0, 3'd4, 8'h14);
    chk("s3.rdy0", 16'(in_ready), 16'd0);
    tick();
    chk("s3.full", 16'(level), 16'd4);
    stall = 1'b0;
    tick();
    chk_out("s3.i0", 3'd0, 8'h10, 1'b1);
    chk("s3.lvl.a", 16'(level), 16'd3);
    tick();
    in_valid = 1'b0;
    chk_out("s3.i1", 3'd1, 8'h11, 1'b1);
    chk("s3.lvl.b", 16'(level), 16'd3);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk_out($sformatf("s3.i%0d", i), 3'(i), 8'(8'h10 + i), 1'b1);
      chk($sformatf("s3.lvl%0d", i), 16'(level), 16'(4 - i));
    end
    tick();
    chk_out("s3.idle", IDLE, 8'h00, 1'b0);

    // Divide by zero dropped, sticky error, cleared by clear
    in_instr = mk(2'd0, 3'b101, 8'h00);
    in_valid = 1'b1;
    tick();
    in_instr = mk(2'd0, 3'b101, 8'h02);
    tick();
    in_valid = 1'b0;
    chk_out("s4.drop", IDLE, 8'h00, 1'b0);
    chk("s4.err1", 16'(div0_err), 16'd1);
    tick();
    chk_out("s4.div", 3'b101, 8'h02, 1'b1);
    chk("s4.err2", 16'(div0_err), 16'd1);
    tick();
    chk("s4.err3", 16'(div0_err), 16'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("s4.errclr", 16'(div0_err), 16'd0);

    // Stall in the middle of a repeat
    push_one(mk(2'd2, 3'b010, 8'h33));
    tick();
    chk_out("s5.first", 3'b010, 8'h33, 1'b1);
    stall = 1'b1;
    tick();
    chk_out("s5.st1", IDLE, 8'h00, 1'b0);
    tick();
    chk_out("s5.st2", IDLE, 8'h00, 1'b0);
    chk("s5.busy", 16'(busy), 16'd1);
    stall = 1'b0;
    tick();
    chk_out("s5.r2", 3'b010, 8'h33, 1'b1);
    tick();
    chk_out("s5.r3", 3'b010, 8'h33, 1'b1);
    tick();
    chk_out("s5.idle", IDLE, 8'h00, 1'b0);
    chk("s5.busy0", 16'(busy), 16'd0);

    // Reset in the middle of a repeat with three queued
    in_valid = 1'b1;
    in_instr = mk(2'd3, 3'b000, 8'hA0);
    tick();
    in_instr = mk(2'd0, 3'b001, 8'hA1);
    tick();
    in_instr = mk(2'd0, 3'b001, 8'hA2);
    tick();
    in_instr = mk(2'd0, 3'b001, 8'hA3);
    tick();
    in_valid = 1'b0;
    chk("s6.lvl3", 16'(level), 16'd3);
    chk_out("s6.rep", 3'b000, 8'hA0, 1'b1);
    reset = 1'b1;
    #1;
    chk_out("s6.rst", IDLE, 8'h00, 1'b0);
    chk("s6.lvl0", 16'(level), 16'd0);
    chk("s6.busy", 16'(busy), 16'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("s6.noiss1", 16'(issue_valid), 16'd0);
    tick();
    chk("s6.noiss2", 16'(issue_valid), 16'd0);
    chk("s6.lvl", 16'(level), 16'd0);

    // Clear together with a push
    push_one(mk(2'd0, 3'b101, 8'h00));
    tick();
    chk("s7.err", 16'(div0_err), 16'd1);
    stall = 1'b1;
    push_one(mk(2'd0, 3'b000, 8'h44));
    chk("s7.lvl1", 16'(level), 16'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_instr = mk(2'd0, 3'b000, 8'h55);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b0;
    chk("s7.lvl0", 16'(level), 16'd0);
    chk("s7.err0", 16'(div0_err), 16'd0);
    chk_out("s7.clr", IDLE, 8'h00, 1'b0);
    tick();
    chk_out("s7.after", IDLE, 8'h00, 1'b0);
    chk("s7.busy", 16'(busy), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
